// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : MIPS32 execute stage. Evaluates logic, shift, conditional-move
//             and HI/LO-move operations combinationally, performs MULT/MULTU
//             in a single cycle and DIV/DIVU on an iterative restoring
//             divider that stalls the pipeline while it runs.
//  Ports    : clk, rst (async, active-high)
//             aluop_i/alusel_i/reg1_i/reg2_i/wd_i/wreg_i : decoded op from id_ex
//             hi_i/lo_i, mem_*/wb_* : architectural HI/LO plus bypass sources
//             flush_i   : cancels an in-flight divide
//             wd_o/wreg_o/wdata_o   : GPR writeback
//             whilo_o/hi_o/lo_o     : HI/LO writeback
//             stallreq_o            : holds IF/ID/EX while the divider works
//  Revision : 1.0  initial release
// ============================================================================
module ex_stage #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        wb_whilo_i,
    input  logic [31:0] wb_hi_i,
    input  logic [31:0] wb_lo_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam int         c_CNT_W  = $clog2(DIV_STEPS);
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [7:0] c_OP_AND   = 8'h24;
    localparam logic [7:0] c_OP_OR    = 8'h25;
    localparam logic [7:0] c_OP_XOR   = 8'h26;
    localparam logic [7:0] c_OP_NOR   = 8'h27;
    localparam logic [7:0] c_OP_SLL   = 8'h7C;
    localparam logic [7:0] c_OP_SRL   = 8'h02;
    localparam logic [7:0] c_OP_SRA   = 8'h03;
    localparam logic [7:0] c_OP_MOVZ  = 8'h0A;
    localparam logic [7:0] c_OP_MOVN  = 8'h0B;
    localparam logic [7:0] c_OP_MFHI  = 8'h10;
    localparam logic [7:0] c_OP_MTHI  = 8'h11;
    localparam logic [7:0] c_OP_MFLO  = 8'h12;
    localparam logic [7:0] c_OP_MTLO  = 8'h13;
    localparam logic [7:0] c_OP_MULT  = 8'h18;
    localparam logic [7:0] c_OP_MULTU = 8'h19;
    localparam logic [7:0] c_OP_DIV   = 8'h1A;
    localparam logic [7:0] c_OP_DIVU  = 8'h1B;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_rem;      // partial remainder, final remainder in DONE
    logic [31:0]        r_quo;      // dividend shifting out / quotient shifting in
    logic [31:0]        r_divisor;
    logic               r_neg_q;
    logic               r_neg_r;

    logic        w_div_op;
    logic        w_div_signed;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_trial;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_div_op     = (aluop_i == c_OP_DIV) || (aluop_i == c_OP_DIVU);
    assign w_div_signed = (aluop_i == c_OP_DIV);

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign w_abs1 = (w_div_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign w_abs2 = (w_div_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

    // Shifted partial remainder is below twice the divisor, so a 33-bit
    // difference is enough to tell whether the subtraction borrows.
    assign w_trial    = {r_rem, r_quo[31]} - {1'b0, r_divisor};
    assign w_rem_next = w_trial[32] ? {r_rem[30:0], r_quo[31]} : w_trial[31:0];
    assign w_quo_next = {r_quo[30:0], ~w_trial[32]};

    // Youngest in-flight HI/LO writer wins.
    assign w_hi = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
    assign w_lo = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

    // Low 64 bits of the sign-extended 64x64 product equal the signed product.
    assign w_prod_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
    assign w_prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (flush_i) begin
            r_state <= c_S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_div_op) begin
                        if (reg2_i == 32'd0) begin
                            r_state <= c_S_DONE;
                            r_quo   <= 32'hFFFF_FFFF;
                            r_rem   <= reg1_i;
                        end else begin
                            r_state   <= c_S_BUSY;
                            r_rem     <= 32'd0;
                            r_quo     <= w_abs1;
                            r_divisor <= w_abs2;
                            r_neg_q   <= w_div_signed && (reg1_i[31] ^ reg2_i[31]);
                            r_neg_r   <= w_div_signed && reg1_i[31];
                            r_count   <= '0;
                        end
                    end
                end
                c_S_BUSY: begin
                    r_count <= r_count + 1'b1;
                    if (r_count == c_CNT_W'(DIV_STEPS - 1)) begin
                        // Last step: apply the sign fix-up while storing.
                        r_state <= c_S_DONE;
                        r_quo   <= r_neg_q ? (~w_quo_next + 32'd1) : w_quo_next;
                        r_rem   <= r_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;
                    end else begin
                        r_quo <= w_quo_next;
                        r_rem <= w_rem_next;
                    end
                end
                c_S_DONE: r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end

    always_comb begin
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'd0;
        whilo_o    = 1'b0;
        hi_o       = 32'd0;
        lo_o       = 32'd0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i;
            case (alusel_i)
                3'b001: begin
                    case (aluop_i)
                        c_OP_OR:  wdata_o = reg1_i | reg2_i;
                        c_OP_AND: wdata_o = reg1_i & reg2_i;
                        c_OP_XOR: wdata_o = reg1_i ^ reg2_i;
                        c_OP_NOR: wdata_o = ~(reg1_i | reg2_i);
                        default:  wdata_o = 32'd0;
                    endcase
                end
                3'b010: begin
                    case (aluop_i)
                        c_OP_SLL: wdata_o = reg2_i << reg1_i[4:0];
                        c_OP_SRL: wdata_o = reg2_i >> reg1_i[4:0];
                        c_OP_SRA: wdata_o = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
                        default:  wdata_o = 32'd0;
                    endcase
                end
                3'b011: begin
                    case (aluop_i)
                        c_OP_MOVZ, c_OP_MOVN: wdata_o = reg1_i;
                        c_OP_MFHI:            wdata_o = w_hi;
                        c_OP_MFLO:            wdata_o = w_lo;
                        default:              wdata_o = 32'd0;
                    endcase
                end
                default: wdata_o = 32'd0;
            endcase

            if (!flush_i) begin
                case (aluop_i)
                    c_OP_MTHI: begin
                        whilo_o = 1'b1;
                        hi_o    = reg1_i;
                        lo_o    = w_lo;
                    end
                    c_OP_MTLO: begin
                        whilo_o = 1'b1;
                        hi_o    = w_hi;
                        lo_o    = reg1_i;
                    end
                    c_OP_MULT: begin
                        whilo_o = 1'b1;
                        {hi_o, lo_o} = w_prod_s;
                    end
                    c_OP_MULTU: begin
                        whilo_o = 1'b1;
                        {hi_o, lo_o} = w_prod_u;
                    end
                    c_OP_DIV, c_OP_DIVU: begin
                        if (r_state == c_S_DONE) begin
                            whilo_o = 1'b1;
                            hi_o    = r_rem;
                            lo_o    = r_quo;
                        end else begin
                            stallreq_o = 1'b1;
                        end
                    end
                    default: whilo_o = 1'b0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
